// File: rtl/bmp_enhance_engine.sv
// Streaming BMP enhancement engine: control FSM, 54-byte BMP header generator
// and per-pixel datapath (brightness add or grayscale invert) behind a single
// registered output stage.
module bmp_enhance_engine #(
  parameter int unsigned TOTAL_BYTES  = 120000,
  parameter int unsigned HEADER_BYTES = 54,
  parameter int unsigned IMG_W        = 200,
  parameter int unsigned IMG_H        = 200,
  parameter int unsigned BRIGHTNESS   = 150
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mode,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        data_signal,
  output logic        done,
  output logic [31:0] data_count
);

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PROCESS, S_DONE} state_t;

  localparam logic [31:0] FILE_SIZE = 32'(HEADER_BYTES + TOTAL_BYTES);
  localparam logic [31:0] W32       = 32'(IMG_W);
  localparam logic [31:0] H32       = 32'(IMG_H);
  localparam logic [31:0] TOTAL32   = 32'(TOTAL_BYTES);
  localparam logic [31:0] LAST_IDX  = 32'(TOTAL_BYTES - 1);
  localparam logic [5:0]  HDR_N     = 6'(HEADER_BYTES);
  localparam logic [8:0]  BOFF      = 9'(BRIGHTNESS % 256);

  state_t      state, state_nx;
  logic        mode_r;
  logic [5:0]  hdr_idx;
  logic [31:0] ld_cnt;     // pixel bytes loaded into the output register
  logic [1:0]  col_cnt;    // bytes of the current triplet collected
  logic [1:0]  emit_cnt;   // inverted-gray repeats still to load
  logic [7:0]  b0, b1, inv_r;

  logic        free, drain, acc, ld, ld_last;
  logic [7:0]  ld_data, bright, inv_now;
  logic [8:0]  bsum;
  logic [9:0]  tsum;

  function automatic logic [7:0] le_byte(input logic [31:0] v, input logic [1:0] k);
    logic [31:0] s;
    s = v >> {k, 3'b000};
    return s[7:0];
  endfunction

  // Fields at 2, 18 and 22 all start on idx[1:0]==2, so idx[1:0]-2 is the byte lane.
  function automatic logic [7:0] hdr_byte(input logic [5:0] idx);
    logic [7:0] b;
    b = '0;
    case (idx)
      6'd0:                      b = 8'h42;
      6'd1:                      b = 8'h4D;
      6'd2, 6'd3, 6'd4, 6'd5:     b = le_byte(FILE_SIZE, idx[1:0] - 2'd2);
      6'd10:                     b = 8'h36;
      6'd14:                     b = 8'h28;
      6'd18, 6'd19, 6'd20, 6'd21: b = le_byte(W32, idx[1:0] - 2'd2);
      6'd22, 6'd23, 6'd24, 6'd25: b = le_byte(H32, idx[1:0] - 2'd2);
      6'd26:                     b = 8'h01;
      6'd28:                     b = 8'h18;
      default:                   b = '0;
    endcase
    return b;
  endfunction

  assign data_signal = (state == S_PROCESS);
  assign done        = (state == S_DONE);

  // Next state, input acceptance and output-register load decisions
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    ld       = 1'b0;
    ld_data  = '0;
    ld_last  = 1'b0;
    free     = !out_valid || out_ready;
    drain    = out_valid && out_ready;
    bsum     = {1'b0, in_data} + BOFF;
    bright   = bsum[8] ? 8'hFF : bsum[7:0];
    tsum     = {2'b00, b0} + {2'b00, b1} + {2'b00, in_data};
    inv_now  = 8'(10'd255 - tsum / 10'd3);
    case (state)
      S_IDLE: if (start) state_nx = S_HEADER;
      S_HEADER: begin
        if (hdr_idx != HDR_N && free) begin
          ld      = 1'b1;
          ld_data = hdr_byte(hdr_idx);
        end
        if (drain && hdr_idx == HDR_N) state_nx = S_PROCESS;
      end
      S_PROCESS: begin
        if (!mode_r) begin
          in_ready = free && (ld_cnt < TOTAL32);
          if (in_valid && in_ready) begin
            ld      = 1'b1;
            ld_data = bright;
            ld_last = (ld_cnt == LAST_IDX);
          end
        end else if (emit_cnt != 2'd0) begin
          if (free) begin
            ld      = 1'b1;
            ld_data = inv_r;
            ld_last = (ld_cnt == LAST_IDX);
          end
        end else begin
          // Third byte is only taken when its result can go straight into the output register.
          in_ready = (ld_cnt < TOTAL32) && (col_cnt != 2'd2 || free);
          if (in_valid && in_ready && col_cnt == 2'd2) begin
            ld      = 1'b1;
            ld_data = inv_now;
            ld_last = (ld_cnt == LAST_IDX);
          end
        end
        if (drain && data_count == LAST_IDX) state_nx = S_DONE;
      end
      S_DONE: if (!start) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    acc = in_valid && in_ready;
  end

  // State, output register and per-image counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      mode_r     <= 1'b0;
      hdr_idx    <= '0;
      ld_cnt     <= '0;
      col_cnt    <= '0;
      emit_cnt   <= '0;
      b0         <= '0;
      b1         <= '0;
      inv_r      <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      data_count <= '0;
    end else begin
      state <= state_nx;
      if (ld) begin
        out_valid <= 1'b1;
        out_data  <= ld_data;
        out_last  <= ld_last;
      end else if (drain) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      case (state)
        S_IDLE: if (start) begin
          mode_r     <= mode;
          data_count <= '0;
          hdr_idx    <= '0;
          ld_cnt     <= '0;
          col_cnt    <= '0;
          emit_cnt   <= '0;
        end
        S_HEADER: if (ld) hdr_idx <= hdr_idx + 6'd1;
        S_PROCESS: begin
          if (drain) data_count <= data_count + 32'd1;
          if (ld) ld_cnt <= ld_cnt + 32'd1;
          if (mode_r) begin
            if (emit_cnt != 2'd0) begin
              if (ld) emit_cnt <= emit_cnt - 2'd1;
            end else if (acc) begin
              case (col_cnt)
                2'd0: begin b0 <= in_data; col_cnt <= 2'd1; end
                2'd1: begin b1 <= in_data; col_cnt <= 2'd2; end
                default: begin
                  inv_r    <= inv_now;
                  emit_cnt <= 2'd2;
                  col_cnt  <= 2'd0;
                end
              endcase
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bmp_enhance_engine.sv
// Directed bench for bmp_enhance_engine with a 12-byte image.
module tb_bmp_enhance_engine;

  logic        clk = 1'b0;
  logic        reset, start, mode, in_valid, out_ready;
  logic [7:0]  in_data;
  logic        in_ready, out_valid, out_last, data_signal, done;
  logic [7:0]  out_data;
  logic [31:0] data_count;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] hdr  [54];
  logic [7:0] pin  [12];
  logic [7:0] pexp [12];
  logic [7:0] expq [66];

  bmp_enhance_engine #(.TOTAL_BYTES(12)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .data_signal(data_signal), .done(done),
    .data_count(data_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Runs one image until stop_after output bytes have handshaken.
  task automatic run_image(input logic m, input int stop_after, input bit bp, input bit flip_mode);
    int ii, oi;
    bit stalled;
    logic [7:0] held;
    for (int k = 0; k < 54; k++) expq[k] = hdr[k];
    for (int k = 0; k < 12; k++) expq[54 + k] = pexp[k];
    ii = 0; oi = 0; stalled = 0; held = '0;
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    for (int cyc = 0; cyc < 3000 && oi < stop_after; cyc++) begin
      @(negedge clk);
      if (flip_mode) mode = ~m;
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = (ii < 12);
      in_data   = (ii < 12) ? pin[ii] : 8'h00;
      #1;
      if (stalled) chk("stall_hold", {23'd0, out_valid, out_data}, {23'd0, 1'b1, held});
      if (oi < 54) chk("hdr_in_ready", in_ready, 1'b0);
      if (in_valid && in_ready) ii++;
      if (out_valid && out_ready) begin
        chk(oi < 54 ? "hdr_byte" : "pix_byte", out_data, expq[oi]);
        chk("out_last", out_last, oi == 65);
        if (oi >= 54) begin
          chk("data_count", data_count, 32'(oi - 54));
          chk("data_signal", data_signal, 1'b1);
        end
        oi++;
      end
      stalled = out_valid && !out_ready;
      held    = out_data;
    end
    if (oi < stop_after) chk("timeout_bytes", 32'(oi), 32'(stop_after));
    in_valid = 1'b0;
  endtask

  task automatic check_done();
    @(negedge clk); #1;
    chk("done", done, 1'b1);
    chk("done_data_signal", data_signal, 1'b0);
    chk("done_count", data_count, 32'd12);
    chk("done_out_valid", out_valid, 1'b0);
    chk("done_in_ready", in_ready, 1'b0);
    repeat (3) @(negedge clk);
    #1 chk("done_hold_start", done, 1'b1);
    start = 1'b0;
    @(negedge clk); #1;
    chk("idle_done", done, 1'b0);
    chk("idle_count_hold", data_count, 32'd12);
  endtask

  task automatic set_bright();
    logic [7:0] a [12] = '{8'h00, 8'h64, 8'h69, 8'h6A, 8'hFF, 8'h01, 8'h10, 8'h5A, 8'h69, 8'h70, 8'h80, 8'hC0};
    logic [7:0] e [12] = '{8'h96, 8'hFA, 8'hFF, 8'hFF, 8'hFF, 8'h97, 8'hA6, 8'hF0, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    for (int k = 0; k < 12; k++) begin pin[k] = a[k]; pexp[k] = e[k]; end
  endtask

  task automatic set_invert();
    logic [7:0] a [12] = '{8'h30, 8'h60, 8'h90, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h01, 8'h00, 8'h10, 8'h20, 8'h33};
    logic [7:0] e [12] = '{8'h9F, 8'h9F, 8'h9F, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hDE, 8'hDE, 8'hDE};
    for (int k = 0; k < 12; k++) begin pin[k] = a[k]; pexp[k] = e[k]; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < 54; k++) hdr[k] = 8'h00;
    hdr[0] = 8'h42; hdr[1] = 8'h4D; hdr[2] = 8'h42;
    hdr[10] = 8'h36; hdr[14] = 8'h28; hdr[18] = 8'hC8; hdr[22] = 8'hC8;
    hdr[26] = 8'h01; hdr[28] = 8'h18;

    reset = 1'b1; start = 1'b0; mode = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_data_signal", data_signal, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_count", data_count, 32'd0);
    @(negedge clk) reset = 1'b0;

    set_bright();
    run_image(1'b0, 66, 1'b0, 1'b0);
    check_done();

    set_invert();
    run_image(1'b1, 66, 1'b1, 1'b1);
    check_done();

    set_bright();
    run_image(1'b0, 66, 1'b1, 1'b0);
    check_done();

    run_image(1'b0, 60, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("amid_out_valid", out_valid, 1'b0);
    chk("amid_out_last", out_last, 1'b0);
    chk("amid_in_ready", in_ready, 1'b0);
    chk("amid_data_signal", data_signal, 1'b0);
    chk("amid_done", done, 1'b0);
    chk("amid_count", data_count, 32'd0);
    start = 1'b0;
    @(negedge clk) reset = 1'b0;
    run_image(1'b0, 66, 1'b0, 1'b0);
    check_done();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
